// File: rtl/fx2_cmd_responder.sv
// fx2_cmd_responder: parses 8-byte host register frames, runs one register-bus
// transaction and streams the 32-bit result back LSB first.
// Optional REG_TIMEOUT_EN: bound the reg_ack wait to TIMEOUT cycles and
// return 0xFFFFFFFF with a sticky timeout_err when it expires.
module fx2_cmd_responder #(
    parameter logic [7:0] MAGIC   = 8'hAA,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_req,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack,
    output logic [7:0]  reply_data,
    output logic        reply_valid,
    input  logic        reply_ready,
    output logic        busy,
    output logic [7:0]  garbage_count,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        REQ,
        REPLY
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [1:0]  rcnt;
    logic [31:0] shift;
    logic        take;
    logic        send;

`ifdef REG_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
    logic [15:0] tcnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_err    = 1'b0;
`endif

    assign take = cmd_valid & cmd_ready;
    assign send = reply_valid & reply_ready;

    // Frame parser, register-bus master and reply serializer in one FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= 3'd0;
            rcnt          <= 2'd0;
            shift         <= 32'd0;
            cmd_ready     <= 1'b0;
            reg_addr      <= 16'd0;
            reg_wdata     <= 32'd0;
            reg_wr        <= 1'b0;
            reg_req       <= 1'b0;
            reply_data    <= 8'd0;
            reply_valid   <= 1'b0;
            busy          <= 1'b0;
            garbage_count <= 8'd0;
`ifdef REG_TIMEOUT_EN
            tcnt          <= 16'd0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (take) begin
                        if (cmd_data == MAGIC) begin
                            state <= COLLECT;
                            idx   <= 3'd0;
                            busy  <= 1'b1;
                        end else if (garbage_count != 8'hFF) begin
                            garbage_count <= garbage_count + 8'd1;
                        end
                    end
                end

                COLLECT: begin
                    if (take) begin
                        // Magic bytes inside a frame are plain payload.
                        unique case (idx)
                            3'd0:    reg_wr           <= cmd_data[0];
                            3'd1:    reg_addr[7:0]    <= cmd_data;
                            3'd2:    reg_addr[15:8]   <= cmd_data;
                            3'd3:    reg_wdata[7:0]   <= cmd_data;
                            3'd4:    reg_wdata[15:8]  <= cmd_data;
                            3'd5:    reg_wdata[23:16] <= cmd_data;
                            3'd6:    reg_wdata[31:24] <= cmd_data;
                            default: ;
                        endcase
                        if (idx == 3'd6) begin
                            state     <= REQ;
                            cmd_ready <= 1'b0;
                            reg_req   <= 1'b1;
`ifdef REG_TIMEOUT_EN
                            tcnt      <= 16'd0;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end

                REQ: begin
                    if (reg_ack) begin
                        reg_req     <= 1'b0;
                        shift       <= reg_rdata;
                        reply_data  <= reg_rdata[7:0];
                        reply_valid <= 1'b1;
                        rcnt        <= 2'd0;
                        state       <= REPLY;
                    end
`ifdef REG_TIMEOUT_EN
                    else if (tcnt == TIMEOUT_M1) begin
                        reg_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        shift       <= 32'hFFFF_FFFF;
                        reply_data  <= 8'hFF;
                        reply_valid <= 1'b1;
                        rcnt        <= 2'd0;
                        state       <= REPLY;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
`endif
                end

                REPLY: begin
                    if (send) begin
                        if (rcnt == 2'd3) begin
                            reply_valid <= 1'b0;
                            cmd_ready   <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            reply_data <= shift[15:8];
                            shift      <= {8'h00, shift[31:8]};
                            rcnt       <= rcnt + 2'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fx2_cmd_responder.md
Name: fx2_cmd_responder

Overview:
Device-side responder for the host register protocol carried over the FX2 OUT endpoint. It consumes the 8-byte command frame: magic 0xAA, write flag, addr[7:0], addr[15:8], val[7:0], val[15:8], val[23:16], val[31:24]. It then issues one register-bus transaction and returns the 4-byte register value, LSB first, on the reply byte stream that feeds the FX2 IN endpoint. It sits between the FX2 FIFO reader/writer and the register file of fx2_timetag.

Parameters:
MAGIC, 8'hAA, frame start byte
TIMEOUT, 255, reg_ack wait limit in clk cycles; used only with REG_TIMEOUT_EN; legal range 1..65535

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cmd_data  in  8  command byte from the FX2 OUT FIFO reader
cmd_valid  in  1  cmd_data valid
cmd_ready  out  1  responder accepts a byte this cycle
reg_addr  out  16  register address
reg_wdata  out  32  register write value
reg_wr  out  1  1 = write, 0 = read; valid while reg_req is high
reg_req  out  1  transaction request, held until ack
reg_rdata  in  32  register value, valid while reg_ack is high
reg_ack  in  1  transaction complete
reply_data  out  8  reply byte to the FX2 IN FIFO writer
reply_valid  out  1  reply_data valid
reply_ready  in  1  downstream accepts the reply byte
busy  out  1  high in every state except IDLE
garbage_count  out  8  saturating count of bytes discarded in IDLE
timeout_err  out  1  sticky flag, set on reg_ack timeout

Behaviour:
- Reset values: cmd_ready=0, reg_req=0, reg_wr=0, reg_addr=0, reg_wdata=0, reply_valid=0, reply_data=0, busy=0, garbage_count=0, timeout_err=0. State=IDLE.
- A byte transfers on a rising edge with cmd_valid&cmd_ready. A reply byte transfers on a rising edge with reply_valid&reply_ready.
- cmd_ready is high only in IDLE and COLLECT. It goes high 1 cycle after reset is released.
- IDLE: an accepted byte equal to MAGIC moves the block to COLLECT with byte index 0. Any other accepted byte is discarded and increments garbage_count, which saturates at 255.
- COLLECT: accepts 7 bytes, using index 0..6.
  - Index 0: write flag. reg_wr is taken from bit0; bits 7:1 are ignored.
  - Index 1-2: reg_addr low byte, then high byte.
  - Index 3-6: reg_wdata, LSB first.
  - A MAGIC value inside a frame is treated as data. There is no resync.
  - When index 6 is accepted at edge N, the block enters REQ. reg_req is high from cycle N+1 and cmd_ready is low from cycle N+1.
- REQ: reg_req, reg_addr, reg_wdata and reg_wr are held stable until reg_ack is sampled high.
  - On the ack edge, reg_rdata is captured into the reply shift register and the block enters REPLY.
  - reg_req is low from the next cycle and reply_valid goes high the same cycle.
  - A reg_ack that arrives while reg_req is low is ignored.
- The reply is always the captured reg_rdata, for both reads and writes. For a write, it is the readback value that the register file presents with the ack.
- REPLY: reply_data = captured[7:0], then [15:8], [23:16], [31:24]. Each byte advances on a transfer.
  - reply_valid stays high between bytes as long as bytes remain.
  - After the 4th transfer, reply_valid drops and the block returns to IDLE. cmd_ready is high on the next cycle.
- Bytes presented during REQ/REPLY are not consumed; upstream holds them.
- reset in any state, including mid-frame, mid-request or mid-reply: return to IDLE, discard partial frame and reply, deassert reg_req and reply_valid, clear garbage_count and timeout_err.
- Minimum frame-to-frame turnaround with an immediate ack and reply_ready tied high: 8 input cycles + 1 REQ + 4 REPLY + 1.

Optional Feature:
- Macro REG_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter runs while in REQ.
  - If TIMEOUT cycles pass with no ack, reg_req drops, timeout_err is set, and the reply is 0xFFFFFFFF.
  - A late reg_ack after the timeout is ignored.
- Without the macro: REQ waits indefinitely, and timeout_err is tied to 0.

Test Plan:
- Garbage: send FF,FF,FF, then a valid read of 0x0001 with reg_rdata=0x00000005 -> garbage_count=3; reg_req is issued once with addr=0x0001, reg_wr=0; reply bytes are 05,00,00,00.
- Write: frame AA,01,03,00,04,00,00,00 with the ack returning 0x00000004 -> reg_wr=1, reg_addr=0x0003, reg_wdata=0x00000004; reg_req rises 1 cycle after the last byte; reply is 04,00,00,00.
- Back-pressure: reply_ready toggling 1/0 per cycle, and the next frame presented during REPLY -> reply bytes arrive in order with none dropped or duplicated; cmd_ready stays 0 until after the 4th reply byte; the next frame is processed correctly.
- Embedded magic: read of addr 0x00AA with value bytes all AA -> reg_addr=0x00AA, reg_wdata=0xAAAAAAAA; no resync occurs; garbage_count is unchanged.
- Reset mid-frame (after the 4th byte) and again during REQ -> all outputs return to reset values next cycle; a following full frame completes normally.
- With REG_TIMEOUT_EN and TIMEOUT=16, no ack -> reg_req drops after 16 cycles; timeout_err=1; reply is FF,FF,FF,FF; an ack at cycle 20 has no effect.
